ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Parametrised successor to the datapath control FSM of the Mini-SRISC CPU. It replaces fixed-latency memory and ALU steps with ready/done handshakes, adds a memory watchdog, flags illegal opcodes, and supports synchronous Stop/Resume at instruction boundaries. It drives the datapath strobes (bus-source selects, register enables, memory and port controls) from IR and status inputs.

Parameters:
REG_COUNT, 16, number of GPRs; width of R_enableIn
LINK_REG, 14, GPR index written by jal
MEM_TIMEOUT, 255, maximum wait cycles for mem_ready before bus error (1..65535)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high
Stop  in  1  halt request, honoured at instruction boundary
Resume  in  1  leave HALTED, clear error flags
IR  in  32  instruction register; opcode IR[31:27]
CON_out  in  1  branch condition result
mem_ready  in  1  memory access complete this cycle
alu_done  in  1  mul/div result valid in Z
PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortout  out  1 each  bus-source selects
MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HIin, LOin, ZHighIn, ZLowIn, R_enable, CON_enable, OutPort_enable  out  1 each  register loads
Gra, Grb, Grc  out  1 each  IR register-field selects
IncPC, MDR_read, RAM_write, mem_req  out  1 each  PC increment, MDR source, write strobe, memory request
R_enableIn  out  REG_COUNT  direct GPR load one-hot
Run, illegal_op, bus_err  out  1 each  status

Behaviour:
- Reset (async): state RESET; all outputs 0, including Run. First clock after release: RESET->FETCH0, Run=1.
- Outputs are decoded from the registered state (Moore). Exception: MDR_enable is also gated by mem_ready in read-wait states.
- FETCH0: PCout, MAR_enable.
- FETCH1: mem_req, MDR_read. MDR_enable=mem_ready. Stays in FETCH1 until mem_ready=1.
- FETCH2: MDRout, IR_enable, IncPC, PC_enable.
- T3 decodes IR[31:27]:
  - ALU3 (3-10): T3 Grb,Rout,Y_enable; T4 Grc,Rout,ZHighIn,ZLowIn; T5 ZLowout,Gra,R_enable.
  - NEG/NOT (16,17): T3 Grb,Rout,ZHighIn,ZLowIn; T4 ZLowout,Gra,R_enable.
  - IMM (addi/andi/ori 11-13): T3 Grb,Rout,Y_enable; T4 Cout,ZHighIn,ZLowIn; T5 ZLowout,Gra,R_enable.
  - ldi (1): same as IMM but T3 uses BAout instead of Rout.
  - MUL/DIV (14,15): T3 Grb,Rout,Y_enable; T4 Grc,Rout,ZHighIn,ZLowIn, held until alu_done=1; T5 ZLowout,LOin; T6 ZHighout,HIin.
  - ld (0): T3 Grb,BAout,Y_enable; T4 Cout,ZHighIn,ZLowIn; T5 ZLowout,MAR_enable; T6 mem_req,MDR_read, MDR_enable=mem_ready, wait for mem_ready; T7 MDRout,Gra,R_enable.
  - st (2): T3-T5 as ld; T6 Gra,Rout,MDR_enable (MDR_read=0); T7 MDRout,mem_req,RAM_write, held until mem_ready.
  - br (18): T3 Gra,Rout,CON_enable; T4 PCout,Y_enable; T5 Cout,ZLowIn; T6 if CON_out: ZLowout,PC_enable, else no strobes.
  - jr (19): T3 Gra,Rout,PC_enable.
  - jal (20): T3 PCout, R_enableIn bit LINK_REG; T4 Gra,Rout,PC_enable.
  - in (21): T3 InPortout,Gra,R_enable.
  - out (22): T3 Gra,Rout,OutPort_enable.
  - mfhi/mflo (23/24): T3 HIout/LOout,Gra,R_enable.
  - nop (25): T3 no strobes.
  - halt (26): go to HALTED.
  - Any other opcode: illegal_op=1, go to HALTED.
- Last step of each instruction goes to FETCH0, or to HALTED if Stop=1 at that edge. Stop never aborts an instruction mid-way.
- HALTED: Run=0, all strobes 0. Resume=1 -> FETCH0, Run=1, illegal_op and bus_err cleared. Resume outside HALTED is ignored.
- Watchdog:
  - 16-bit counter, cleared on entry to any memory-wait state; increments each cycle with mem_ready=0.
  - When it reaches MEM_TIMEOUT: bus_err=1, go to HALTED, mem_req dropped.
  - mem_ready on the same edge as the timeout takes priority (access completes).
- alu_done has no timeout.
- Reset mid-instruction: immediate return to RESET; error flags cleared.

Decomposition:
- Package ctrl_pkg holds: the opcode constants (5-bit), the state enumeration (RESET, FETCH0-2, T3-T7, HALTED), and an opcode-class function (ALU3, ALU2, IMM, LDI, MULDIV, LD, ST, BR, JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT, ILLEGAL).
- One sub-module, ctrl_mem_watchdog: counter, clear, enable, timeout flag.

Test Plan:
- Reset release; add (op 3), mem_ready 2 cycles after FETCH1 entry -> FETCH1 lasts 3 cycles, MDR_enable high only in cycle 3; T5 asserts ZLowout, Gra, R_enable; Run=1.
- mul (op 14), alu_done 5 cycles after T4 -> ZHighIn/ZLowIn held 5 cycles; LOin at T5, HIin at T6; next state FETCH0.
- br (op 18) with CON_out=1 -> T6 ZLowout and PC_enable. Repeat with CON_out=0 -> T6 all strobes 0.
- Stop pulsed during ld T4 -> ld completes T7 with R_enable, then HALTED, Run=0. Resume -> FETCH0, Run=1.
- Opcode 31 -> illegal_op=1, HALTED. Resume clears illegal_op.
- MEM_TIMEOUT=8, st with mem_ready stuck 0 -> bus_err=1 after 8 wait cycles, mem_req and RAM_write drop. Reset asserted mid-ld T6 -> all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states and
// the opcode-class decode used to select each instruction's step sequence.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    typedef enum logic [3:0] {
        RESET, FETCH0, FETCH1, FETCH2, T3, T4, T5, T6, T7, HALTED
    } state_t;

    typedef enum logic [4:0] {
        C_ALU3, C_ALU2, C_IMM, C_LDI, C_MULDIV, C_LD, C_ST, C_BR, C_JR,
        C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    // Group opcodes that share the same step sequence.
    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        case (op) inside
            [OP_ADD:OP_OR]:   c = C_ALU3;
            OP_NEG, OP_NOT:   c = C_ALU2;
            [OP_ADDI:OP_ORI]: c = C_IMM;
            OP_LDI:           c = C_LDI;
            OP_MUL, OP_DIV:   c = C_MULDIV;
            OP_LD:            c = C_LD;
            OP_ST:            c = C_ST;
            OP_BR:            c = C_BR;
            OP_JR:            c = C_JR;
            OP_JAL:           c = C_JAL;
            OP_IN:            c = C_IN;
            OP_OUT:           c = C_OUT;
            OP_MFHI:          c = C_MFHI;
            OP_MFLO:          c = C_MFLO;
            OP_NOP:           c = C_NOP;
            OP_HALT:          c = C_HALT;
            default:          c = C_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ctrl_mem_watchdog.sv
// Counts stalled cycles of a memory wait and flags the cycle on which the
// wait would reach MEM_TIMEOUT, so the sequencer can abandon the access.
module ctrl_mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT - 1);

    logic [15:0] count;

    // Stall counter: held at zero outside wait states, saturates at the top.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != 16'hFFFF)
            count <= count + 16'd1;
    end

    assign timeout = enable && (count == LIMIT);

endmodule

// File: rtl/ctrl_sequencer.sv
// Datapath control FSM with memory/ALU handshakes, memory watchdog,
// illegal-opcode detection and Stop/Resume at instruction boundaries.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int REG_COUNT   = 16,
    parameter int LINK_REG    = 14,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Stop,
    input  logic                 Resume,
    input  logic [31:0]          IR,
    input  logic                 CON_out,
    input  logic                 mem_ready,
    input  logic                 alu_done,
    output logic                 PCout, ZHighout, ZLowout, MDRout, HIout,
    output logic                 LOout, Cout, BAout, Rout, InPortout,
    output logic                 MAR_enable, PC_enable, MDR_enable, IR_enable,
    output logic                 Y_enable, HIin, LOin, ZHighIn, ZLowIn,
    output logic                 R_enable, CON_enable, OutPort_enable,
    output logic                 Gra, Grb, Grc,
    output logic                 IncPC, MDR_read, RAM_write, mem_req,
    output logic [REG_COUNT-1:0] R_enableIn,
    output logic                 Run, illegal_op, bus_err
);

    state_t    state, state_n;
    op_class_t cls;
    logic      in_wait, timeout, done, stop_pend, halt_req;
    logic      set_illegal, set_buserr, clr_flags;
    logic      unused_ir_bits;

    assign cls            = op_class(IR[31:27]);
    assign unused_ir_bits = ^IR[26:0];
    assign halt_req       = Stop | stop_pend;
    assign Run            = (state != RESET) && (state != HALTED);
    assign in_wait        = (state == FETCH1) || (state == T6 && cls == C_LD)
                          || (state == T7 && cls == C_ST);

    ctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (!in_wait),
        .enable  (in_wait && !mem_ready),
        .timeout (timeout)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= RESET;
        else       state <= state_n;
    end

    // Latch a Stop request until the current instruction finishes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                                stop_pend <= 1'b0;
        else if (state == HALTED || state == RESET) stop_pend <= 1'b0;
        else if (Stop)                            stop_pend <= 1'b1;
    end

    // Sticky error flags, cleared only by Resume out of HALTED or Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else if (clr_flags) begin
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (set_illegal) illegal_op <= 1'b1;
            if (set_buserr)  bus_err    <= 1'b1;
        end
    end

    // Next-state and strobe decode from the registered state and IR class.
    always_comb begin
        {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, BAout, Rout,
         InPortout} = '0;
        {MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HIin, LOin,
         ZHighIn, ZLowIn, R_enable, CON_enable, OutPort_enable} = '0;
        {Gra, Grb, Grc, IncPC, MDR_read, RAM_write, mem_req} = '0;
        R_enableIn  = '0;
        state_n     = state;
        done        = 1'b0;
        set_illegal = 1'b0;
        set_buserr  = 1'b0;
        clr_flags   = 1'b0;
        case (state)
            RESET:  state_n = FETCH0;
            FETCH0: begin
                PCout = 1'b1; MAR_enable = 1'b1; state_n = FETCH1;
            end
            FETCH1: begin
                mem_req = 1'b1; MDR_read = 1'b1; MDR_enable = mem_ready;
                if (mem_ready)    state_n = FETCH2;
                else if (timeout) begin state_n = HALTED; set_buserr = 1'b1; end
            end
            FETCH2: begin
                MDRout = 1'b1; IR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1;
                state_n = T3;
            end
            T3: begin
                state_n = T4;
                case (cls)
                    C_ALU3, C_IMM, C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1; end
                    C_LDI, C_LD, C_ST:       begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
                    C_ALU2: begin Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
                    C_BR:   begin Gra = 1'b1; Rout = 1'b1; CON_enable = 1'b1; end
                    C_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; done = 1'b1; end
                    C_JAL:  begin PCout = 1'b1; R_enableIn[LINK_REG] = 1'b1; end
                    C_IN:   begin InPortout = 1'b1; Gra = 1'b1; R_enable = 1'b1; done = 1'b1; end
                    C_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1; done = 1'b1; end
                    C_MFHI: begin HIout = 1'b1; Gra = 1'b1; R_enable = 1'b1; done = 1'b1; end
                    C_MFLO: begin LOout = 1'b1; Gra = 1'b1; R_enable = 1'b1; done = 1'b1; end
                    C_NOP:  done = 1'b1;
                    C_HALT: state_n = HALTED;
                    default: begin state_n = HALTED; set_illegal = 1'b1; end
                endcase
            end
            T4: begin
                state_n = T5;
                case (cls)
                    C_ALU3: begin Grc = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
                    C_MULDIV: begin
                        Grc = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
                        if (!alu_done) state_n = T4;
                    end
                    C_ALU2: begin ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1; done = 1'b1; end
                    C_IMM, C_LDI, C_LD, C_ST: begin Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
                    C_BR:   begin PCout = 1'b1; Y_enable = 1'b1; end
                    C_JAL:  begin Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1; done = 1'b1; end
                    default: done = 1'b1;
                endcase
            end
            T5: begin
                state_n = T6;
                case (cls)
                    C_ALU3, C_IMM, C_LDI: begin ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1; done = 1'b1; end
                    C_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; end
                    C_LD, C_ST: begin ZLowout = 1'b1; MAR_enable = 1'b1; end
                    C_BR:   begin Cout = 1'b1; ZLowIn = 1'b1; end
                    default: done = 1'b1;
                endcase
            end
            T6: begin
                state_n = T7;
                case (cls)
                    C_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; done = 1'b1; end
                    C_LD: begin
                        mem_req = 1'b1; MDR_read = 1'b1; MDR_enable = mem_ready;
                        if (!mem_ready) begin
                            state_n = T6;
                            if (timeout) begin state_n = HALTED; set_buserr = 1'b1; end
                        end
                    end
                    C_ST: begin Gra = 1'b1; Rout = 1'b1; MDR_enable = 1'b1; end
                    C_BR: begin
                        if (CON_out) begin ZLowout = 1'b1; PC_enable = 1'b1; end
                        done = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            T7: begin
                case (cls)
                    C_LD: begin MDRout = 1'b1; Gra = 1'b1; R_enable = 1'b1; done = 1'b1; end
                    C_ST: begin
                        MDRout = 1'b1; mem_req = 1'b1; RAM_write = 1'b1;
                        if (mem_ready)    done = 1'b1;
                        else if (timeout) begin state_n = HALTED; set_buserr = 1'b1; end
                    end
                    default: done = 1'b1;
                endcase
            end
            HALTED: begin
                if (Resume) begin state_n = FETCH0; clr_flags = 1'b1; end
            end
            default: state_n = RESET;
        endcase
        if (done) state_n = halt_req ? HALTED : FETCH0;
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: walks instructions step by step and
// compares the packed strobe vector against hand-written masks.
module tb_ctrl_sequencer;

    logic Clock, Reset, Stop, Resume, CON_out, mem_ready, alu_done;
    logic [31:0] IR;
    logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortout;
    logic MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HIin, LOin;
    logic ZHighIn, ZLowIn, R_enable, CON_enable, OutPort_enable;
    logic Gra, Grb, Grc, IncPC, MDR_read, RAM_write, mem_req;
    logic [15:0] R_enableIn;
    logic Run, illegal_op, bus_err;
    logic [28:0] strobes;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [28:0] M_PCOUT = 29'd1 << 28, M_ZHO  = 29'd1 << 27, M_ZLO  = 29'd1 << 26,
                            M_MDRO  = 29'd1 << 25, M_HIO  = 29'd1 << 24, M_LOO  = 29'd1 << 23,
                            M_COUT  = 29'd1 << 22, M_BAO  = 29'd1 << 21, M_ROUT = 29'd1 << 20,
                            M_INPO  = 29'd1 << 19, M_MARE = 29'd1 << 18, M_PCE  = 29'd1 << 17,
                            M_MDRE  = 29'd1 << 16, M_IRE  = 29'd1 << 15, M_YE   = 29'd1 << 14,
                            M_HIIN  = 29'd1 << 13, M_LOIN = 29'd1 << 12, M_ZHI  = 29'd1 << 11,
                            M_ZLI   = 29'd1 << 10, M_RE   = 29'd1 << 9,  M_CONE = 29'd1 << 8,
                            M_OUTE  = 29'd1 << 7,  M_GRA  = 29'd1 << 6,  M_GRB  = 29'd1 << 5,
                            M_GRC   = 29'd1 << 4,  M_INC  = 29'd1 << 3,  M_MDRRD = 29'd1 << 2,
                            M_RAMWR = 29'd1 << 1,  M_MREQ = 29'd1 << 0;

    assign strobes = {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortout,
                      MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HIin, LOin,
                      ZHighIn, ZLowIn, R_enable, CON_enable, OutPort_enable,
                      Gra, Grb, Grc, IncPC, MDR_read, RAM_write, mem_req};

    ctrl_sequencer #(.REG_COUNT(16), .LINK_REG(14), .MEM_TIMEOUT(8)) dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .Resume(Resume), .IR(IR),
        .CON_out(CON_out), .mem_ready(mem_ready), .alu_done(alu_done),
        .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .InPortout(InPortout), .MAR_enable(MAR_enable), .PC_enable(PC_enable),
        .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .R_enable(R_enable), .CON_enable(CON_enable), .OutPort_enable(OutPort_enable),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .MDR_read(MDR_read),
        .RAM_write(RAM_write), .mem_req(mem_req), .R_enableIn(R_enableIn),
        .Run(Run), .illegal_op(illegal_op), .bus_err(bus_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // Check the strobes of the current step, then advance one clock.
    task automatic step(input string tag, input logic [28:0] mask);
        check(tag, {3'd0, strobes}, {3'd0, mask});
        tick();
    endtask

    // Fetch starting in FETCH0; mem_ready arrives after wait_n stalled cycles.
    task automatic fetch(input logic [4:0] op, input int wait_n, input string tag);
        IR = {op, 27'd0};
        check({tag, ".run"}, {31'd0, Run}, 32'd1);
        step({tag, ".f0"}, M_PCOUT | M_MARE);
        for (int i = 0; i <= wait_n; i++) begin
            mem_ready = (i == wait_n);
            #1;
            step({tag, ".f1"}, M_MREQ | M_MDRRD | ((i == wait_n) ? M_MDRE : 29'd0));
        end
        mem_ready = 1'b0;
        step({tag, ".f2"}, M_MDRO | M_IRE | M_INC | M_PCE);
    endtask

    initial begin
        Reset = 1'b1; Stop = 1'b0; Resume = 1'b0; CON_out = 1'b0;
        mem_ready = 1'b0; alu_done = 1'b0; IR = '0;
        #2;
        check("rst.strobes", {3'd0, strobes}, 32'd0);
        check("rst.run", {31'd0, Run}, 32'd0);
        check("rst.flags", {30'd0, illegal_op, bus_err}, 32'd0);
        @(negedge Clock); Reset = 1'b0;
        tick();

        // add: fetch with two stalled cycles
        fetch(5'd3, 2, "add");
        step("add.t3", M_GRB | M_ROUT | M_YE);
        step("add.t4", M_GRC | M_ROUT | M_ZHI | M_ZLI);
        step("add.t5", M_ZLO | M_GRA | M_RE);

        // mul: alu_done on the fifth T4 cycle
        fetch(5'd14, 0, "mul");
        step("mul.t3", M_GRB | M_ROUT | M_YE);
        for (int i = 0; i < 5; i++) begin
            alu_done = (i == 4);
            step("mul.t4", M_GRC | M_ROUT | M_ZHI | M_ZLI);
        end
        alu_done = 1'b0;
        step("mul.t5", M_ZLO | M_LOIN);
        step("mul.t6", M_ZHO | M_HIIN);

        // br taken then not taken
        for (int k = 1; k >= 0; k--) begin
            CON_out = 1'(k);
            fetch(5'd18, 0, "br");
            step("br.t3", M_GRA | M_ROUT | M_CONE);
            step("br.t4", M_PCOUT | M_YE);
            step("br.t5", M_COUT | M_ZLI);
            step("br.t6", (k == 1) ? (M_ZLO | M_PCE) : 29'd0);
        end
        CON_out = 1'b0;

        // jal: link register one-hot
        fetch(5'd20, 0, "jal");
        check("jal.rin", {16'd0, R_enableIn}, 32'h0000_4000);
        step("jal.t3", M_PCOUT);
        step("jal.t4", M_GRA | M_ROUT | M_PCE);

        // nop: mem_ready on the timeout cycle still completes the fetch
        fetch(5'd25, 7, "nop");
        check("nop.buserr", {31'd0, bus_err}, 32'd0);
        step("nop.t3", 29'd0);

        // ld with Stop pulsed in T4: finishes, then HALTED
        fetch(5'd0, 0, "ld");
        step("ld.t3", M_GRB | M_BAO | M_YE);
        Stop = 1'b1;
        step("ld.t4", M_COUT | M_ZHI | M_ZLI);
        Stop = 1'b0;
        step("ld.t5", M_ZLO | M_MARE);
        mem_ready = 1'b1; #1;
        step("ld.t6", M_MREQ | M_MDRRD | M_MDRE);
        mem_ready = 1'b0;
        step("ld.t7", M_MDRO | M_GRA | M_RE);
        check("halt.run", {31'd0, Run}, 32'd0);
        step("halt.s0", 29'd0);
        step("halt.s1", 29'd0);
        check("halt.hold", {31'd0, Run}, 32'd0);
        Resume = 1'b1;
        tick();
        Resume = 1'b0;

        // illegal opcode 31
        fetch(5'd31, 0, "ill");
        step("ill.t3", 29'd0);
        check("ill.flag", {31'd0, illegal_op}, 32'd1);
        check("ill.run", {31'd0, Run}, 32'd0);
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        check("ill.clear", {31'd0, illegal_op}, 32'd0);

        // st with mem_ready stuck low: bus error after 8 waits
        fetch(5'd2, 0, "st");
        step("st.t3", M_GRB | M_BAO | M_YE);
        step("st.t4", M_COUT | M_ZHI | M_ZLI);
        step("st.t5", M_ZLO | M_MARE);
        step("st.t6", M_GRA | M_ROUT | M_MDRE);
        for (int i = 0; i < 8; i++) begin
            check("st.noerr", {31'd0, bus_err}, 32'd0);
            step("st.t7", M_MDRO | M_MREQ | M_RAMWR);
        end
        check("st.buserr", {31'd0, bus_err}, 32'd1);
        check("st.drop", {3'd0, strobes}, 32'd0);
        check("st.run", {31'd0, Run}, 32'd0);
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        check("st.clear", {31'd0, bus_err}, 32'd0);

        // Reset asserted while ld waits in T6
        fetch(5'd0, 0, "ldr");
        step("ldr.t3", M_GRB | M_BAO | M_YE);
        step("ldr.t4", M_COUT | M_ZHI | M_ZLI);
        step("ldr.t5", M_ZLO | M_MARE);
        check("ldr.t6", {3'd0, strobes}, {3'd0, M_MREQ | M_MDRRD});
        Reset = 1'b1;
        #1;
        check("ldr.rst", {3'd0, strobes}, 32'd0);
        check("ldr.rstrun", {31'd0, Run}, 32'd0);
        @(negedge Clock); Reset = 1'b0;
        tick();
        check("ldr.restart", {3'd0, strobes}, {3'd0, M_PCOUT | M_MARE});
        check("ldr.run", {31'd0, Run}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
